write_behind_buf: RTL and testbench
===================================

# write_behind_buf

Two-entry elastic buffer on the write port of a standard single-clock FIFO. It is the write-side counterpart of the read-ahead buffer. A producer writes into it with a plain `w_req`/`w_data` strobe and sees a `full` flag driven only from registers. The block forwards stored words into the FIFO whenever the FIFO is not full, which adds an effective two words of depth in front of the FIFO. It sits between producer logic and `fifo_single_clock_reg_v1`. Its purpose is to cut the combinational path from the FIFO's `full` output back to the producer.

## Interface
- `DATA_W`, 16: data word width in bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `anrst`  in  1  asynchronous active-low reset.
- `w_req`  in  1  producer write strobe; one word per cycle while high.
- `w_data`  in  DATA_W  producer write data, sampled when `w_req && ~full`.
- `full`  out  1  buffer holds 2 words; derived from registers only.
- `cnt`  out  2  number of words held, 0..2.
- `fifo_w_req`  out  1  write strobe to the downstream FIFO.
- `fifo_w_data`  out  DATA_W  oldest stored word, presented to the FIFO.
- `fifo_full`  in  1  full flag from the downstream FIFO.
- `ovf`  out  1  sticky overflow flag (see Configuration).

## Operation
- Storage:
  - two `DATA_W` entries, a 1-bit write pointer `wp` and a 1-bit read pointer `rp`, a 2-bit count `cnt`;
  - pointers wrap 1 -> 0.
- Handshake definitions:
  - `push = w_req && ~full`;
  - `pop = fifo_w_req`;
  - `fifo_w_req = (cnt != 0) && ~fifo_full`;
  - `fifo_w_data = mem[rp]`.
- Updates each cycle:
  - push writes `mem[wp] <= w_data` and advances `wp`;
  - pop advances `rp`;
  - `cnt <= cnt + push - pop`.
- `full = (cnt == 2)`. It does not depend on `fifo_full` or `w_req` in the same cycle.
- `w_req` while `full` is dropped. Storage, pointers and `cnt` are unchanged.
- There is no bypass: a word written into an empty buffer reaches the FIFO no earlier than the next cycle.
- Word order is strictly preserved, with no duplication and no loss, except for words dropped under `full`.
- Simultaneous events:
  - `cnt=1`, push and pop in the same cycle: `cnt` stays 1. Steady-state throughput is 1 word/cycle.
  - `cnt=2` and `w_req`: the write is dropped, even if a pop occurs that cycle, because `full` is registered. `cnt` becomes 1 if popped.
  - `cnt=0`: `fifo_w_req` is 0 regardless of `fifo_full`.
- Reset, asynchronous and applicable at any time, including mid-transfer:
  - `cnt`, `wp`, `rp`, `ovf` <= 0;
  - storage <= 0;
  - outputs immediately read `full=0`, `cnt=0`, `fifo_w_req=0`, `fifo_w_data=0`, `ovf=0`;
  - words in flight are discarded.

## Timing
- Latency from `w_req` sampled to `fifo_w_req` high: 1 cycle when `fifo_full=0`.
- `full` rises 1 cycle after the push that brings `cnt` to 2. It falls 1 cycle after the first pop from `cnt=2`.
- `fifo_w_req` and `fifo_w_data` are combinational from `cnt`, `rp`, storage and `fifo_full`. The FIFO samples them on the same edge that pops them here.
- `fifo_full` going high stalls output in the same cycle. Up to 2 further producer words are absorbed before `full` rises.
- Critical path to the producer: register -> compare -> `full`. There is no path from `fifo_full` to `full`.

## Configuration
- Macro `WRITE_BEHIND_BUF_OVF_EN`.
- Defined: `ovf` is a register, set to 1 on any cycle with `w_req && full`. It stays 1 until `anrst` is asserted.
- Not defined: `ovf` is tied to constant 0 and no overflow logic is built. Datapath behaviour is identical in both builds.

## Test plan
- Reset then single write: `w_data=16'hA5A5` with `fifo_full=0` -> next cycle `fifo_w_req=1`, `fifo_w_data=16'hA5A5`, `cnt=1`; one cycle later `cnt=0`.
- Streaming: writes of 0..99 every cycle with `fifo_full=0` -> FIFO receives 0..99 in order, one per cycle after the first, `full` never asserted.
- Back-pressure: `fifo_full=1`, write 1, 2, 3 on consecutive cycles -> `cnt=2`, `full=1` after word 2, word 3 dropped. Release `fifo_full` -> FIFO receives 1, 2 only.
- Simultaneous at full: `cnt=2`, `fifo_full=0`, `w_req=1` with data 7 -> 7 dropped, `cnt=1`. With `WRITE_BEHIND_BUF_OVF_EN` defined `ovf=1`, without it `ovf=0`.
- Reset mid-operation: `cnt=2`, then pulse `anrst` low between edges -> outputs are 0 without waiting for a clock edge. The next write 16'h1234 is the first word the FIFO sees.
- Randomised stimulus with a 32-deep FIFO behind and a 34-deep reference FIFO fed by the same producer: read streams match exactly and no word is dropped while `full=0`.

Source files
------------

// File: rtl/write_behind_buf_if.sv
// Producer-side and FIFO-side signals of write_behind_buf.
// slave: the buffer itself; master: the producer plus downstream FIFO driving it.
interface write_behind_buf_if #(
    parameter int unsigned DATA_W = 16
);
    logic              w_req;
    logic [DATA_W-1:0] w_data;
    logic              full;
    logic [1:0]        cnt;
    logic              fifo_w_req;
    logic [DATA_W-1:0] fifo_w_data;
    logic              fifo_full;
    logic              ovf;

    modport slave (
        input  w_req, w_data, fifo_full,
        output full, cnt, fifo_w_req, fifo_w_data, ovf
    );

    modport master (
        output w_req, w_data, fifo_full,
        input  full, cnt, fifo_w_req, fifo_w_data, ovf
    );
endinterface

// File: rtl/write_behind_buf.sv
// Two-entry write-behind buffer in front of a single-clock FIFO; full comes from registers only.
// Define WRITE_BEHIND_BUF_OVF_EN to build the sticky overflow flag (otherwise ovf is tied to 0).
module write_behind_buf #(
    parameter int unsigned DATA_W = 16
) (
    input logic                clk,
    input logic                anrst,
    write_behind_buf_if.slave  bus
);
    logic [DATA_W-1:0] mem_q [2];
    logic              wp_q;
    logic              rp_q;
    logic [1:0]        cnt_q;
    logic              full;
    logic              push;
    logic              pop;

    // full must not see fifo_full or w_req: it is a pure compare on cnt_q
    assign full            = (cnt_q == 2'd2);
    assign push            = bus.w_req && !full;
    assign pop             = (cnt_q != 2'd0) && !bus.fifo_full;

    assign bus.full        = full;
    assign bus.cnt         = cnt_q;
    assign bus.fifo_w_req  = pop;
    assign bus.fifo_w_data = mem_q[rp_q];

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wp_q] <= bus.w_data;
                wp_q        <= ~wp_q;
            end
            if (pop) begin
                rp_q <= ~rp_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef WRITE_BEHIND_BUF_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            ovf_q <= 1'b0;
        end else if (bus.w_req && full) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_write_behind_buf.sv
// Self-checking bench for write_behind_buf: vector table, streaming, reset and randomised runs.
module tb_write_behind_buf;
    localparam int unsigned DATA_W = 16;
`ifdef WRITE_BEHIND_BUF_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk;
    logic anrst;
    int   n_tests;
    int   n_fail;

    write_behind_buf_if #(.DATA_W(DATA_W)) bus ();

    write_behind_buf #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .anrst (anrst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w_req;
        logic [15:0] w_data;
        logic        fifo_full;
        logic [1:0]  cnt;
        logic        full;
        logic        fwr;
        logic [15:0] fwd;
        logic        ovf;
    } vec_t;

    vec_t vecs [13];

    logic [15:0] exp_q  [$];
    logic [15:0] ref_q  [$];
    logic [15:0] down_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Leaves the bench at posedge+1 with reset released and idle inputs.
    task automatic do_reset();
        anrst         = 1'b0;
        bus.w_req     = 1'b0;
        bus.w_data    = '0;
        bus.fifo_full = 1'b0;
        #12;
        chk("rst_cnt", 32'(bus.cnt), 32'd0);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_fwr", 32'(bus.fifo_w_req), 32'd0);
        chk("rst_fwd", 32'(bus.fifo_w_data), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        anrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        model_full;
        logic        model_pop;
        logic        model_push;
        logic [1:0]  model_cnt;
        logic [15:0] got;
        int          rx;

        n_tests = 0;
        n_fail  = 0;

        // back-pressure, single write, simultaneous-at-full sequence
        vecs[0]  = '{1'b1, 16'h0001, 1'b1, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 16'h0002, 1'b1, 2'd1, 1'b0, 1'b0, 16'h0001, 1'b0};
        vecs[2]  = '{1'b1, 16'h0003, 1'b1, 2'd2, 1'b1, 1'b0, 16'h0001, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b0, 2'd2, 1'b1, 1'b1, 16'h0001, OVF_EN};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 2'd1, 1'b0, 1'b1, 16'h0002, OVF_EN};
        vecs[5]  = '{1'b1, 16'hA5A5, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0001, OVF_EN};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 2'd1, 1'b0, 1'b1, 16'hA5A5, OVF_EN};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 2'd0, 1'b0, 1'b0, 16'h0002, OVF_EN};
        vecs[8]  = '{1'b1, 16'h0010, 1'b1, 2'd0, 1'b0, 1'b0, 16'h0002, OVF_EN};
        vecs[9]  = '{1'b1, 16'h0011, 1'b1, 2'd1, 1'b0, 1'b0, 16'h0010, OVF_EN};
        vecs[10] = '{1'b1, 16'h0007, 1'b0, 2'd2, 1'b1, 1'b1, 16'h0010, OVF_EN};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 2'd1, 1'b0, 1'b1, 16'h0011, OVF_EN};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0010, OVF_EN};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            bus.w_req     = vecs[i].w_req;
            bus.w_data    = vecs[i].w_data;
            bus.fifo_full = vecs[i].fifo_full;
            @(negedge clk);
            chk($sformatf("vec%0d_cnt", i), 32'(bus.cnt), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_full", i), 32'(bus.full), 32'(vecs[i].full));
            chk($sformatf("vec%0d_fwr", i), 32'(bus.fifo_w_req), 32'(vecs[i].fwr));
            chk($sformatf("vec%0d_fwd", i), 32'(bus.fifo_w_data), 32'(vecs[i].fwd));
            chk($sformatf("vec%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].ovf));
            @(posedge clk);
            #1;
        end

        // streaming 0..99 with the FIFO never full
        do_reset();
        exp_q.delete();
        rx = 0;
        for (int i = 0; i < 110; i++) begin
            bus.w_req     = (i < 100);
            bus.w_data    = 16'(i);
            bus.fifo_full = 1'b0;
            @(negedge clk);
            chk("stream_full", 32'(bus.full), 32'd0);
            if (bus.fifo_w_req) begin
                if (exp_q.size() == 0) begin
                    chk("stream_unexpected", 32'(bus.fifo_w_data), 32'hFFFF_FFFF);
                end else begin
                    chk("stream_data", 32'(bus.fifo_w_data), 32'(exp_q.pop_front()));
                end
                rx++;
            end
            if (bus.w_req) exp_q.push_back(bus.w_data);
            @(posedge clk);
            #1;
        end
        chk("stream_count", 32'(rx), 32'd100);

        // asynchronous reset between edges with two words held
        do_reset();
        bus.w_req     = 1'b1;
        bus.w_data    = 16'h0055;
        bus.fifo_full = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.w_req     = 1'b0;
        bus.fifo_full = 1'b0;
        chk("mid_cnt_pre", 32'(bus.cnt), 32'd2);
        #2;
        anrst = 1'b0;
        #1;
        chk("mid_full", 32'(bus.full), 32'd0);
        chk("mid_cnt", 32'(bus.cnt), 32'd0);
        chk("mid_fwr", 32'(bus.fifo_w_req), 32'd0);
        chk("mid_fwd", 32'(bus.fifo_w_data), 32'd0);
        chk("mid_ovf", 32'(bus.ovf), 32'd0);
        #1;
        anrst = 1'b1;
        @(posedge clk);
        #1;
        bus.w_req  = 1'b1;
        bus.w_data = 16'h1234;
        @(posedge clk);
        #1;
        bus.w_req = 1'b0;
        @(negedge clk);
        chk("mid_next_fwr", 32'(bus.fifo_w_req), 32'd1);
        chk("mid_next_fwd", 32'(bus.fifo_w_data), 32'h1234);
        @(posedge clk);
        #1;

        // randomised run: 32-deep FIFO behind, reference queue of accepted words
        do_reset();
        ref_q.delete();
        down_q.delete();
        model_cnt = 2'd0;
        for (int c = 0; c < 3100; c++) begin
            logic rd;
            bus.w_req     = (c < 3000) && ($urandom_range(0, 3) != 0);
            bus.w_data    = 16'($urandom);
            bus.fifo_full = (down_q.size() >= 32);
            @(negedge clk);
            model_full = (model_cnt == 2'd2);
            model_pop  = (model_cnt != 2'd0) && !bus.fifo_full;
            model_push = bus.w_req && !model_full;
            chk("rnd_full", 32'(bus.full), 32'(model_full));
            chk("rnd_fwr", 32'(bus.fifo_w_req), 32'(model_pop));
            if (c >= 3000) rd = 1'b1;
            else if (((c / 400) % 2) == 0) rd = ($urandom_range(0, 3) == 0);
            else rd = ($urandom_range(0, 3) != 0);
            if (rd && down_q.size() > 0) begin
                got = down_q.pop_front();
                if (ref_q.size() == 0) begin
                    chk("rnd_extra", 32'(got), 32'hFFFF_FFFF);
                end else begin
                    chk("rnd_data", 32'(got), 32'(ref_q.pop_front()));
                end
            end
            if (bus.fifo_w_req) down_q.push_back(bus.fifo_w_data);
            if (model_push) ref_q.push_back(bus.w_data);
            model_cnt = model_cnt + {1'b0, model_push} - {1'b0, model_pop};
            @(posedge clk);
            #1;
        end
        chk("rnd_ref_left", 32'(ref_q.size()), 32'd0);
        chk("rnd_down_left", 32'(down_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
